pulse_gen: RTL and testbench
============================

PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the bit width of the period, high-time and frame counter.
REQ-002 The block SHALL have parameter RESET_MODE, default 2'd0, meaning the active mode loaded at reset.
REQ-003 Port clock  input  1  single clock; all state updates on the falling edge.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on the falling edge of clock.
REQ-005 Port enable  input  1  run enable; 0 freezes the generator idle.
REQ-006 Port load  input  1  one-cycle strobe capturing mode, period and high_time into shadow registers.
REQ-007 Port mode  input  2  0 OFF, 1 SQUARE, 2 PWM, 3 ONESHOT.
REQ-008 Port period  input  WIDTH  frame length minus one.
REQ-009 Port high_time  input  WIDTH  high cycles per frame (PWM) or pulse length (ONESHOT).
REQ-010 Port start  input  1  ONESHOT trigger.
REQ-011 Port signal  output  1  registered waveform.
REQ-012 Port tick  output  1  one-cycle strobe at frame end or pulse end.
REQ-013 Port busy  output  1  generator active.
REQ-014 Port count  output  WIDTH  current frame counter value.

Function
REQ-015 The block SHALL keep active configuration (a_mode, a_period, a_high), shadow configuration and a pending flag.
REQ-016 A load SHALL set pending; a later load before apply SHALL overwrite the shadow.
REQ-017 Pending SHALL apply at the next frame boundary, or on the next edge if enable=0, a_mode=OFF, or ONESHOT is idle.
REQ-018 Load coincident with a boundary SHALL apply the new configuration at that boundary; signal SHALL restart low and count SHALL restart at 0.
REQ-019 With enable=0 or a_mode=OFF: count=0, signal=0, tick=0, busy=0.
REQ-020 Frame rule (SQUARE, PWM): count increments by 1 per edge 0..a_period; at count==a_period it SHALL wrap to 0 and tick SHALL be 1 for that next cycle.
REQ-021 SQUARE: signal SHALL toggle at each wrap, giving period 2*(a_period+1) cycles; a_period=0 toggles every cycle.
REQ-022 PWM: signal SHALL be 1 when count < a_high, else 0, evaluated on the registered count (same cycle alignment).
REQ-023 PWM with a_high=0 SHALL stay low; with a_high > a_period SHALL stay high; tick SHALL still pulse.
REQ-024 ONESHOT idle: count=0, signal=0, busy=0.
REQ-025 ONESHOT: start=1 with enable=1 SHALL set busy=1 next cycle, with signal=1 for exactly a_high cycles, then signal=0, busy=0 and tick=1 for one cycle; a_period is ignored.
REQ-026 ONESHOT with a_high=0: start SHALL produce tick=1 one cycle later, signal stays 0, and busy is never set.
REQ-027 start while busy, or in modes other than ONESHOT, SHALL be ignored.
REQ-028 enable dropping mid-operation SHALL abort immediately to idle; pulses are not resumed.
REQ-029 busy SHALL be 1 in SQUARE and PWM whenever enable=1.
REQ-030 Counter arithmetic SHALL be unsigned WIDTH bits with no overflow beyond a_period.

Reset
REQ-031 On reset=1 at a falling edge: signal=0, tick=0, busy=0, count=0, pending=0, a_mode=RESET_MODE, a_period=0, a_high=0, shadow cleared.
REQ-032 Reset SHALL dominate load, start and enable in the same cycle and SHALL abort any operation in progress.

Verification
REQ-033 SQUARE, period=1, enable=1 -> signal toggles every 2 falling edges (divide-by-4), tick every 2nd cycle.
REQ-034 PWM, period=9, high_time=3 -> per 10-cycle frame signal high at count 0..2, low at 3..9, tick once per frame; high_time=0 gives always low and 12 gives always high.
REQ-035 PWM running at period=9, load period=4 at count=5 -> old frame completes to 9, then 5-cycle frames start.
REQ-036 ONESHOT, high_time=5, start pulse -> busy 1 and signal high 5 cycles, then tick 1 cycle; second start during pulse ignored.
REQ-037 Reset asserted mid-PWM frame at count=6 -> next cycle all outputs 0, a_mode=OFF; no activity until load.
REQ-038 enable deasserted mid-ONESHOT -> signal=0, busy=0 next cycle, no tick.

Source files
------------

// File: rtl/pulse_gen.sv
// pulse_gen: square / PWM / one-shot waveform generator on the falling clock
// edge, with shadowed configuration applied at frame boundaries.
//
// mode state | meaning
// -----------+-----------------------------------------------------------
// OFF        | generator held idle, all outputs low
// SQUARE     | free-running frames, signal toggles at every frame wrap
// PWM        | free-running frames, signal high while count < a_high
// ONESHOT    | idle until start, then a_high-cycle pulse ended by tick
module pulse_gen #(
    parameter int         WIDTH      = 8,
    parameter logic [1:0] RESET_MODE = 2'd0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] high_time,
    input  logic             start,
    output logic             signal,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_SQUARE  = 2'd1;
    localparam logic [1:0] MODE_PWM     = 2'd2;
    localparam logic [1:0] MODE_ONESHOT = 2'd3;

    // active configuration
    logic [1:0]       a_mode_q, a_mode_d;
    logic [WIDTH-1:0] a_period_q, a_period_d;
    logic [WIDTH-1:0] a_high_q, a_high_d;

    // shadow configuration awaiting a safe point to take effect
    logic [1:0]       s_mode_q, s_mode_d;
    logic [WIDTH-1:0] s_period_q, s_period_d;
    logic [WIDTH-1:0] s_high_q, s_high_d;
    logic             pending_q, pending_d;

    // registered outputs
    logic             signal_q, signal_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] count_q, count_d;

    // decode helpers
    logic             frame_mode_q;
    logic             os_running;
    logic             wrap;
    logic             idle_cond;
    logic             apply_wrap;
    logic             apply_idle;
    logic [WIDTH-1:0] count_inc;

    // Decide whether this edge is a frame boundary or an idle point where
    // a pending configuration may be swapped in.
    always_comb begin
        frame_mode_q = (a_mode_q == MODE_SQUARE) || (a_mode_q == MODE_PWM);
        os_running   = (a_mode_q == MODE_ONESHOT) && busy_q;
        // busy_q distinguishes a running frame from the first enabled edge
        wrap         = enable && frame_mode_q && busy_q && (count_q >= a_period_q);
        idle_cond    = !enable || (a_mode_q == MODE_OFF) ||
                       ((a_mode_q == MODE_ONESHOT) && !busy_q);
        // a load landing exactly on the boundary takes effect there directly
        apply_wrap   = wrap && (load || pending_q);
        apply_idle   = idle_cond && pending_q;
        count_inc    = count_q + WIDTH'(1);
    end

    // Active and shadow configuration update.
    always_comb begin
        a_mode_d   = a_mode_q;
        a_period_d = a_period_q;
        a_high_d   = a_high_q;
        s_mode_d   = s_mode_q;
        s_period_d = s_period_q;
        s_high_d   = s_high_q;
        pending_d  = pending_q;

        if (apply_wrap) begin
            if (load) begin
                a_mode_d   = mode;
                a_period_d = period;
                a_high_d   = high_time;
                s_mode_d   = mode;
                s_period_d = period;
                s_high_d   = high_time;
            end else begin
                a_mode_d   = s_mode_q;
                a_period_d = s_period_q;
                a_high_d   = s_high_q;
            end
            pending_d = 1'b0;
        end else if (apply_idle) begin
            a_mode_d   = s_mode_q;
            a_period_d = s_period_q;
            a_high_d   = s_high_q;
            // a load on the same edge queues behind the one being applied
            pending_d  = load;
            if (load) begin
                s_mode_d   = mode;
                s_period_d = period;
                s_high_d   = high_time;
            end
        end else if (load) begin
            s_mode_d   = mode;
            s_period_d = period;
            s_high_d   = high_time;
            pending_d  = 1'b1;
        end
    end

    // Waveform, counter, tick and busy, computed with the configuration in
    // force for this edge (a_*_d already reflects any apply).
    always_comb begin
        signal_d = 1'b0;
        tick_d   = 1'b0;
        busy_d   = 1'b0;
        count_d  = '0;

        if (!enable || (a_mode_d == MODE_OFF)) begin
            signal_d = 1'b0;
        end else if ((a_mode_d == MODE_SQUARE) || (a_mode_d == MODE_PWM)) begin
            busy_d = 1'b1;
            if (wrap) begin
                count_d = '0;
                tick_d  = 1'b1;
                if (a_mode_d == MODE_SQUARE) begin
                    // a fresh configuration restarts the square phase low
                    signal_d = apply_wrap ? 1'b0 : !signal_q;
                end else begin
                    signal_d = (a_high_d != '0);
                end
            end else if (!busy_q) begin
                // first enabled edge: frame starts at count 0
                count_d  = '0;
                signal_d = (a_mode_d == MODE_PWM) && (a_high_d != '0);
            end else begin
                count_d = count_inc;
                if (a_mode_d == MODE_SQUARE) begin
                    signal_d = signal_q;
                end else begin
                    signal_d = (count_inc < a_high_d);
                end
            end
        end else begin
            if (os_running) begin
                if (count_inc >= a_high_q) begin
                    tick_d = 1'b1;
                end else begin
                    count_d  = count_inc;
                    signal_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end else if (start) begin
                if (a_high_d == '0) begin
                    // zero-length pulse: report completion only
                    tick_d = 1'b1;
                end else begin
                    signal_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
        end
    end

    // All state advances on the falling edge; reset overrides everything.
    always_ff @(negedge clock) begin
        if (reset) begin
            a_mode_q   <= RESET_MODE;
            a_period_q <= '0;
            a_high_q   <= '0;
            s_mode_q   <= '0;
            s_period_q <= '0;
            s_high_q   <= '0;
            pending_q  <= 1'b0;
            signal_q   <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            a_mode_q   <= a_mode_d;
            a_period_q <= a_period_d;
            a_high_q   <= a_high_d;
            s_mode_q   <= s_mode_d;
            s_period_q <= s_period_d;
            s_high_q   <= s_high_d;
            pending_q  <= pending_d;
            signal_q   <= signal_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
        end
    end

    assign signal = signal_q;
    assign tick   = tick_q;
    assign busy   = busy_q;
    assign count  = count_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed self-checking bench for pulse_gen. Inputs change 1 time unit
// after each falling edge; outputs are checked at that same point.
module tb_pulse_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic [1:0] mode;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       start;
    logic       signal;
    logic       tick;
    logic       busy;
    logic [7:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    pulse_gen #(.WIDTH(8), .RESET_MODE(2'd0)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .mode      (mode),
        .period    (period),
        .high_time (high_time),
        .start     (start),
        .signal    (signal),
        .tick      (tick),
        .busy      (busy),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    // load a configuration while disabled, then let it apply
    task automatic config_idle(input logic [1:0] m, input logic [7:0] p, input logic [7:0] h);
        enable = 1'b0; load = 1'b1; mode = m; period = p; high_time = h;
        cyc();
        load = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; load = 1'b1; mode = 2'd1; period = 8'd1;
        high_time = 8'd1; start = 1'b1;
        cyc();
        cyc();
        n_tests++;
        if ({signal, tick, busy, count} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got sig=%0b tick=%0b busy=%0b cnt=%0d want all 0", signal, tick, busy, count);
        end
        reset = 1'b0; load = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if ({signal, tick, busy, count} !== 11'd0) begin
                n_fail++;
                $display("FAIL reset_off_idle[%0d] got sig=%0b busy=%0b cnt=%0d want all 0", i, signal, busy, count);
            end
        end
    endtask

    task automatic test_square();
        config_idle(2'd1, 8'd1, 8'd0);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_tests++;
            if (count !== 8'(i % 2) || signal !== 1'((i / 2) % 2) ||
                tick !== 1'((i % 2 == 0) && (i > 0)) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL square[%0d] got cnt=%0d sig=%0b tick=%0b busy=%0b want cnt=%0d sig=%0b tick=%0b busy=1",
                         i, count, signal, tick, busy, i % 2, (i / 2) % 2, (i % 2 == 0) && (i > 0));
            end
        end
        enable = 1'b0;
        cyc();
        n_tests++;
        if ({signal, tick, busy, count} !== 11'd0) begin
            n_fail++;
            $display("FAIL square_disable got sig=%0b tick=%0b busy=%0b cnt=%0d want all 0", signal, tick, busy, count);
        end
    endtask

    task automatic test_pwm();
        config_idle(2'd2, 8'd9, 8'd3);
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_tests++;
            if (count !== 8'(i % 10) || signal !== 1'((i % 10) < 3) ||
                tick !== 1'((i % 10 == 0) && (i > 0)) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL pwm[%0d] got cnt=%0d sig=%0b tick=%0b busy=%0b want cnt=%0d sig=%0b tick=%0b",
                         i, count, signal, tick, busy, i % 10, (i % 10) < 3, (i % 10 == 0) && (i > 0));
            end
        end
    endtask

    task automatic test_pwm_extremes();
        logic [7:0] hv;
        for (int k = 0; k < 2; k++) begin
            hv = (k == 0) ? 8'd0 : 8'd12;
            config_idle(2'd2, 8'd9, hv);
            enable = 1'b1;
            for (int i = 0; i < 20; i++) begin
                cyc();
                n_tests++;
                if (signal !== (hv != 8'd0) || count !== 8'(i % 10) ||
                    tick !== 1'((i % 10 == 0) && (i > 0))) begin
                    n_fail++;
                    $display("FAIL pwm_high%0d[%0d] got sig=%0b cnt=%0d tick=%0b want sig=%0b cnt=%0d tick=%0b",
                             hv, i, signal, count, tick, hv != 8'd0, i % 10, (i % 10 == 0) && (i > 0));
                end
            end
        end
    endtask

    task automatic test_pwm_reload();
        int exp_c[13] = '{7, 8, 9, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
        config_idle(2'd2, 8'd9, 8'd3);
        enable = 1'b1;
        repeat (6) cyc();
        n_tests++;
        if (count !== 8'd5) begin
            n_fail++;
            $display("FAIL reload_pre got cnt=%0d want 5", count);
        end
        load = 1'b1; mode = 2'd2; period = 8'd4; high_time = 8'd3;
        cyc();
        load = 1'b0;
        n_tests++;
        if (count !== 8'd6 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_hold got cnt=%0d tick=%0b want cnt=6 tick=0", count, tick);
        end
        for (int j = 0; j < 13; j++) begin
            cyc();
            n_tests++;
            if (count !== 8'(exp_c[j]) || tick !== (exp_c[j] == 0) ||
                (j != 3 && signal !== (exp_c[j] < 3))) begin
                n_fail++;
                $display("FAIL reload[%0d] got cnt=%0d tick=%0b sig=%0b want cnt=%0d tick=%0b sig=%0b",
                         j, count, tick, signal, exp_c[j], exp_c[j] == 0, exp_c[j] < 3);
            end
        end
    endtask

    task automatic test_oneshot();
        config_idle(2'd3, 8'd7, 8'd5);
        enable = 1'b1;
        cyc();
        n_tests++;
        if ({signal, tick, busy, count} !== 11'd0) begin
            n_fail++;
            $display("FAIL os_idle got sig=%0b tick=%0b busy=%0b cnt=%0d want all 0", signal, tick, busy, count);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                start = (i == 2);
                cyc();
                start = 1'b0;
            end
            n_tests++;
            if (busy !== 1'b1 || signal !== 1'b1 || tick !== 1'b0 || count !== 8'(i)) begin
                n_fail++;
                $display("FAIL os_pulse[%0d] got busy=%0b sig=%0b tick=%0b cnt=%0d want busy=1 sig=1 tick=0 cnt=%0d",
                         i, busy, signal, tick, count, i);
            end
        end
        cyc();
        n_tests++;
        if (tick !== 1'b1 || busy !== 1'b0 || signal !== 1'b0) begin
            n_fail++;
            $display("FAIL os_end got tick=%0b busy=%0b sig=%0b want tick=1 busy=0 sig=0", tick, busy, signal);
        end
        cyc();
        n_tests++;
        if ({signal, tick, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL os_after got sig=%0b tick=%0b busy=%0b want 0", signal, tick, busy);
        end
    endtask

    task automatic test_oneshot_zero();
        load = 1'b1; mode = 2'd3; period = 8'd7; high_time = 8'd0;
        cyc();
        load = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_tests++;
        if (tick !== 1'b1 || busy !== 1'b0 || signal !== 1'b0) begin
            n_fail++;
            $display("FAIL os_zero got tick=%0b busy=%0b sig=%0b want tick=1 busy=0 sig=0", tick, busy, signal);
        end
        cyc();
        n_tests++;
        if ({signal, tick, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL os_zero_after got sig=%0b tick=%0b busy=%0b want 0", signal, tick, busy);
        end
    endtask

    task automatic test_enable_abort();
        load = 1'b1; mode = 2'd3; period = 8'd7; high_time = 8'd5;
        cyc();
        load = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        n_tests++;
        if (busy !== 1'b1 || signal !== 1'b1 || count !== 8'd1) begin
            n_fail++;
            $display("FAIL abort_pre got busy=%0b sig=%0b cnt=%0d want busy=1 sig=1 cnt=1", busy, signal, count);
        end
        enable = 1'b0;
        cyc();
        n_tests++;
        if ({signal, tick, busy, count} !== 11'd0) begin
            n_fail++;
            $display("FAIL abort got sig=%0b tick=%0b busy=%0b cnt=%0d want all 0", signal, tick, busy, count);
        end
        enable = 1'b1;
        cyc();
        n_tests++;
        if ({signal, tick, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_no_resume got sig=%0b tick=%0b busy=%0b want 0", signal, tick, busy);
        end
    endtask

    task automatic test_reset_mid_pwm();
        config_idle(2'd2, 8'd9, 8'd3);
        enable = 1'b1;
        repeat (7) cyc();
        n_tests++;
        if (count !== 8'd6) begin
            n_fail++;
            $display("FAIL rst_pwm_pre got cnt=%0d want 6", count);
        end
        reset = 1'b1; load = 1'b1; mode = 2'd1; period = 8'd2; start = 1'b1;
        cyc();
        reset = 1'b0; load = 1'b0; start = 1'b0;
        n_tests++;
        if ({signal, tick, busy, count} !== 11'd0) begin
            n_fail++;
            $display("FAIL rst_pwm got sig=%0b tick=%0b busy=%0b cnt=%0d want all 0", signal, tick, busy, count);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_tests++;
            if ({signal, tick, busy, count} !== 11'd0) begin
                n_fail++;
                $display("FAIL rst_quiet[%0d] got sig=%0b tick=%0b busy=%0b cnt=%0d want all 0", i, signal, tick, busy, count);
            end
        end
        load = 1'b1; mode = 2'd2; period = 8'd9; high_time = 8'd3;
        cyc();
        load = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_load_pending got busy=%0b want 0", busy);
        end
        cyc();
        n_tests++;
        if (busy !== 1'b1 || count !== 8'd0 || signal !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_reload got busy=%0b cnt=%0d sig=%0b want busy=1 cnt=0 sig=1", busy, count, signal);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; mode = 2'd0;
        period = 8'd0; high_time = 8'd0; start = 1'b0;
        #1;
        test_reset();
        test_square();
        test_pwm();
        test_pwm_extremes();
        test_pwm_reload();
        test_oneshot();
        test_oneshot_zero();
        test_enable_abort();
        test_reset_mid_pwm();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
